// File: rtl/riscv_pkg.sv
// Shared RV32 types and constants for the front-end pipeline stages.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory, redirect and decode-side handshake bundle of the fetch stage.
interface fetch_unit_if;
  import riscv_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [ILEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// In-order FIFO of fetch packets with flush; head is read combinationally from storage.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  fetch_pkt_t    data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_pkt_t    data_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_pkt_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && count_q == CW'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// RV32 fetch stage: owns the PC, issues credit-limited word fetches, queues returned
// instructions for decode and discards stale responses after a redirect.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 2,
  parameter int unsigned     CW       = $clog2(DEPTH + 1)
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count;
  logic [CW:0]     inflight;
  logic [XLEN-1:0] target;
  logic            req_fire, keep, pop;
  fetch_pkt_t      push_pkt, head;

  assign target   = word_align(bus.redirect_pc);
  // Buffered plus outstanding never exceeds DEPTH, so a response always has a slot.
  assign inflight = {1'b0, outst_q} + {1'b0, count};

  assign bus.imem_req_valid = !rst && !bus.redirect_valid && (inflight < (CW+1)'(DEPTH));
  assign bus.imem_req_addr  = pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign keep     = bus.imem_rsp_valid && !bus.redirect_valid && (drop_q == '0);
  assign push_pkt = '{instr: bus.imem_rsp_data, pc: rsp_pc_q};

  assign bus.if_valid = !rst && !bus.redirect_valid && (count != '0);
  assign pop          = bus.if_valid && bus.if_ready;
  assign bus.if_instr = rst ? '0 : head.instr;
  assign bus.if_pc    = rst ? '0 : head.pc;

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    drop_d   = drop_q;
    outst_d  = outst_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
    if (bus.redirect_valid) begin
      pc_d     = target;
      rsp_pc_d = target;
      // Everything still in flight is stale; a response landing now is already discarded.
      drop_d   = outst_q - CW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (keep)     rsp_pc_d = rsp_pc_q + 32'd4;
      if (bus.imem_rsp_valid && drop_q != '0) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (keep),
    .data_i  (push_pkt),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .data_o  (head),
    .count_o (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector table plus scoreboarded
// multi-cycle sequences (stall, redirect, redirect-with-response, PC wrap and reset).
module tb_fetch_unit;

  localparam logic [31:0] MAIN_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WIDE_RESET_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst, rst_w;

  fetch_unit_if bus ();
  fetch_unit_if bus_w ();

  fetch_unit #(.RESET_PC(MAIN_RESET_PC)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  fetch_unit #(.RESET_PC(WIDE_RESET_PC)) u_dut_w (.clk(clk), .rst(rst_w), .bus(bus_w));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    bit          rst;
    bit          if_rdy;
    bit          rq_rdy;
    bit          e_rv;
    logic [31:0] e_addr;
    bit          e_iv;
    logic [31:0] e_pc;
  } vec_t;

  exp_t        sb[$];
  logic [31:0] mem_q[$];
  logic [31:0] memw_q[$];
  logic [31:0] accw_q[$];
  logic [31:0] pcw_q[$];
  logic [31:0] inw_q[$];
  vec_t        vecs[$];
  bit          mem_hold;
  logic [31:0] exp_pc;
  logic [31:0] last_if_pc;
  int          n_cmp, n_bad, n_pop;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h0000_0013;
  endfunction

  function automatic vec_t mk(input bit r, input bit ir, input bit qr, input bit rv,
                              input logic [31:0] a, input bit iv, input logic [31:0] p);
    vec_t v;
    v = '{rst: r, if_rdy: ir, rq_rdy: qr, e_rv: rv, e_addr: a, e_iv: iv, e_pc: p};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Memory for the main DUT: drives the head response unless held, then lets inputs settle.
  task automatic settle();
    if (!rst && !mem_hold && mem_q.size() > 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mem_q[0]);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
    #1;
  endtask

  task automatic commit();
    exp_t e;
    if (rst) begin
      mem_q.delete();
      sb.delete();
      exp_pc = MAIN_RESET_PC;
    end else begin
      if (bus.redirect_valid)
        check("redirect_quiet", {30'b0, bus.if_valid, bus.imem_req_valid}, 32'h0);
      if (bus.if_valid && bus.if_ready) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_if_valid");
        end else begin
          e = sb.pop_front();
          check("sb_if_pc", bus.if_pc, e.pc);
          check("sb_if_instr", bus.if_instr, e.instr);
        end
        last_if_pc = bus.if_pc;
        n_pop++;
      end
      if (bus.imem_rsp_valid) void'(mem_q.pop_front());
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        check("req_addr", bus.imem_req_addr, exp_pc);
        exp_pc = bus.imem_req_addr + 32'd4;
        mem_q.push_back(bus.imem_req_addr);
        sb.push_back('{instr: mem_word(bus.imem_req_addr), pc: bus.imem_req_addr});
      end
      if (bus.redirect_valid) begin
        sb.delete();
        exp_pc = {bus.redirect_pc[31:2], 2'b00};
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    commit();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_pop(input int bound, input string name);
    int p0;
    p0 = n_pop;
    for (int i = 0; i < bound && n_pop == p0; i++) step();
    if (n_pop == p0) fail_now(name);
  endtask

  task automatic drain(input int bound);
    bus.imem_req_ready = 1'b0;
    mem_hold = 1'b0;
    for (int i = 0; i < bound && (sb.size() != 0 || mem_q.size() != 0); i++) step();
    if (sb.size() != 0 || mem_q.size() != 0) fail_now("drain_timeout");
  endtask

  task automatic step_w();
    if (!rst_w && memw_q.size() > 0) begin
      bus_w.imem_rsp_valid = 1'b1;
      bus_w.imem_rsp_data  = mem_word(memw_q[0]);
    end else begin
      bus_w.imem_rsp_valid = 1'b0;
      bus_w.imem_rsp_data  = '0;
    end
    #1;
    if (rst_w) begin
      memw_q.delete();
    end else begin
      if (bus_w.imem_rsp_valid) void'(memw_q.pop_front());
      if (bus_w.imem_req_valid && bus_w.imem_req_ready) begin
        accw_q.push_back(bus_w.imem_req_addr);
        memw_q.push_back(bus_w.imem_req_addr);
      end
      if (bus_w.if_valid && bus_w.if_ready) begin
        pcw_q.push_back(bus_w.if_pc);
        inw_q.push_back(bus_w.if_instr);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] wexp [4];
    vec_t        v;
    bit          found;

    n_cmp = 0; n_bad = 0; n_pop = 0;
    mem_hold = 1'b0;
    exp_pc = MAIN_RESET_PC;
    last_if_pc = '0;
    rst = 1'b1;
    rst_w = 1'b1;
    bus.imem_req_ready = 1'b0; bus.if_ready = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus_w.imem_req_ready = 1'b0; bus_w.if_ready = 1'b0;
    bus_w.redirect_valid = 1'b0; bus_w.redirect_pc = '0;
    bus_w.imem_rsp_valid = 1'b0; bus_w.imem_rsp_data = '0;

    // Per-cycle vectors from reset release: streaming, then decode stalled.
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h8,  1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'hC,  1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h8));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h8,  1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h8,  1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h8,  1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h8,  1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'hC,  1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h8));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rst = v.rst;
      bus.if_ready = v.if_rdy;
      bus.imem_req_ready = v.rq_rdy;
      settle();
      check($sformatf("vec%0d_req_valid", i), 32'(bus.imem_req_valid), 32'(v.e_rv));
      if (v.e_rv) check($sformatf("vec%0d_req_addr", i), bus.imem_req_addr, v.e_addr);
      check($sformatf("vec%0d_if_valid", i), 32'(bus.if_valid), 32'(v.e_iv));
      if (v.e_iv || v.rst) check($sformatf("vec%0d_if_pc", i), bus.if_pc, v.e_pc);
      if (v.rst) check($sformatf("vec%0d_if_instr", i), bus.if_instr, 32'h0);
      commit();
    end
    drain(30);

    // Memory stalls with 0x10 pending: address must hold and be fetched once.
    do_reset();
    bus.if_ready = 1'b1;
    bus.imem_req_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      settle();
      if (bus.imem_req_valid && bus.imem_req_addr == 32'h10) found = 1'b1;
      else commit();
    end
    if (!found) fail_now("stall_setup_timeout");
    bus.imem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) settle();
      else #1;
      check("stall_req_valid", 32'(bus.imem_req_valid), 32'h1);
      check("stall_req_addr", bus.imem_req_addr, 32'h10);
      commit();
    end
    bus.imem_req_ready = 1'b1;
    settle();
    check("stall_resume_addr", bus.imem_req_addr, 32'h10);
    commit();
    for (int i = 0; i < 4; i++) step();
    drain(30);

    // Redirect with 0x20 and 0x24 both in flight.
    do_reset();
    mem_hold = 1'b1;
    bus.if_ready = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h20;
    step();
    bus.redirect_valid = 1'b0;
    step();
    step();
    settle();
    check("credit_exhausted", 32'(bus.imem_req_valid), 32'h0);
    commit();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0102;
    step();
    bus.redirect_valid = 1'b0;
    mem_hold = 1'b0;
    wait_pop(20, "redirect_pop_timeout");
    check("redirect_first_if_pc", last_if_pc, 32'h100);
    drain(30);

    // Redirect in the same cycle a response arrives.
    do_reset();
    mem_hold = 1'b1;
    bus.if_ready = 1'b1;
    bus.imem_req_ready = 1'b1;
    step();
    step();
    mem_hold = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    step();
    bus.redirect_valid = 1'b0;
    wait_pop(20, "redirect_rsp_pop_timeout");
    check("redirect_rsp_first_if_pc", last_if_pc, 32'h200);
    drain(30);

    // Second instance: PC wrap from the top of the address space, then mid-stream reset.
    rst = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_req_ready = 1'b0;
    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0; wexp[3] = 32'h4;
    step_w();
    rst_w = 1'b0;
    bus_w.imem_req_ready = 1'b1;
    bus_w.if_ready = 1'b1;
    for (int i = 0; i < 30 && pcw_q.size() < 4; i++) step_w();
    if (accw_q.size() < 4 || pcw_q.size() < 4) fail_now("wrap_timeout");
    else begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("wrap_req%0d", i), accw_q[i], wexp[i]);
        check($sformatf("wrap_if_pc%0d", i), pcw_q[i], wexp[i]);
        check($sformatf("wrap_if_instr%0d", i), inw_q[i], mem_word(wexp[i]));
      end
    end
    rst_w = 1'b1;
    step_w();
    #1;
    check("rst_req_valid", 32'(bus_w.imem_req_valid), 32'h0);
    check("rst_if_valid", 32'(bus_w.if_valid), 32'h0);
    check("rst_if_pc", bus_w.if_pc, 32'h0);
    check("rst_if_instr", bus_w.if_instr, 32'h0);
    rst_w = 1'b0;
    accw_q.delete();
    for (int i = 0; i < 10 && accw_q.size() == 0; i++) step_w();
    if (accw_q.size() == 0) fail_now("refetch_timeout");
    else check("refetch_addr", accw_q[0], WIDE_RESET_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
